muldiv_unit: RTL and testbench

//   Iterative RV32M/RV64M multiply-divide execute unit. It sits beside the

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 88 ++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle between the execute stage and muldiv_unit
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    modport master (
        output in_valid, funct3, op1, op2, in_tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );
    modport slave (
        input  in_valid, funct3, op1, op2, in_tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide, one result bit per cycle
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             r_state, w_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_f3;
    logic [TAG_W-1:0]   r_tag;
    logic [XLEN-1:0]    r_a, r_b, r_res;
    logic [2*XLEN-1:0]  r_acc;
    logic               r_neg;
    logic               w_go, w_s1, w_s2, w_neg, w_dz, w_ovf, w_spec;
    logic [XLEN-1:0]    w_abs1, w_abs2, w_sres, w_madd, w_q, w_r, w_fin;
    logic [XLEN:0]      w_msum, w_diff;
    logic [2*XLEN-1:0]  w_step, w_prod;
    // Operands are held as magnitudes; r_neg is the sign of the selected result
    assign w_s1   = bus.op1[XLEN-1] & (bus.funct3[2] ? ~bus.funct3[0] : bus.funct3[1:0] != 2'b11);
    assign w_s2   = bus.op2[XLEN-1] & (bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1]);
    assign w_neg  = (bus.funct3[2] & bus.funct3[1]) ? w_s1 : w_s1 ^ w_s2;
    assign w_abs1 = w_s1 ? -bus.op1 : bus.op1;
    assign w_abs2 = w_s2 ? -bus.op2 : bus.op2;
    assign w_dz   = bus.funct3[2] & ~|bus.op2;
    assign w_ovf  = bus.funct3[2] & ~bus.funct3[0] & (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op2);
    assign w_spec = w_dz | w_ovf;
    assign w_sres = w_dz ? (bus.funct3[1] ? bus.op1 : '1) : (bus.funct3[1] ? '0 : bus.op1);
    assign w_go   = bus.in_valid & ~bus.flush & (r_state == IDLE);
    // Multiply: add into the upper half, shift right. Divide: {rem, quotient} shift left.
    assign w_madd = r_b[0] ? r_a : '0;
    assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_madd};
    assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    assign w_step = r_f3[2] ? (w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                            : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1})
                            : {w_msum, r_acc[XLEN-1:1]};
    assign w_prod = r_neg ? -w_step : w_step;
    assign w_q    = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_r    = r_neg ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
    assign w_fin  = r_f3[2] ? (r_f3[1] ? w_r : w_q)
                            : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_state;
    always_comb
        w_state = bus.flush          ? IDLE :
                  r_state == IDLE    ? (w_go ? (w_spec ? DONE : CALC) : IDLE) :
                  r_state == CALC    ? (r_cnt == '0 ? DONE : CALC) :
                  bus.out_ready      ? IDLE : DONE;
    always_comb begin
        bus.in_ready  = r_state == IDLE;
        bus.out_valid = r_state == DONE;
        bus.busy      = r_state != IDLE;
        bus.result    = r_res;
        bus.out_tag   = r_tag;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_f3  <= '0;
            r_tag <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_acc <= '0;
            r_neg <= 1'b0;
        end else if (w_go) begin
            r_f3  <= bus.funct3;
            r_tag <= bus.in_tag;
            r_a   <= w_abs1;
            r_b   <= w_abs2;
            r_neg <= w_neg;
            r_cnt <= CW'(XLEN - 1);
            r_acc <= bus.funct3[2] ? {{XLEN{1'b0}}, w_abs1} : '0;
            if (w_spec)
                r_res <= w_sres;
        end else if (r_state == CALC && !bus.flush) begin
            r_acc <= w_step;
            r_b   <= r_f3[2] ? r_b : r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0)
                r_res <= w_fin;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, backpressure, flush and reset
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus();
    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_tag   = t;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op1      = 32'hDEADBEEF;
        bus.op2      = 32'h0;
        bus.in_tag   = 5'd0;
    endtask

    // lat counts rising edges from the accept edge (inclusive) until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_cmp++; if (bus.out_tag !== 5'h0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        logic [2:0]  f [8] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b010, 3'b001};
        logic [31:0] a [8] = '{32'd7, 32'hFFFFFFFC, 32'h00010000, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b [8] = '{32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00010000, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e [8] = '{32'hFFFFFFEB, 32'd20, 32'h0, 32'h40000000, 32'hC0000000, 32'h40000000, 32'hFFFFFFFF, 32'h0};
        int lat;
        for (int i = 0; i < 8; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 5));
            wait_result(lat);
            n_cmp++; if (bus.result !== e[i]) begin n_err++; $display("FAIL mul_result[%0d]: got %h want %h", i, bus.result, e[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat); end
            n_cmp++; if (bus.out_tag !== 5'(i + 5)) begin n_err++; $display("FAIL mul_tag[%0d]: got %0d want %0d", i, bus.out_tag, i + 5); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div;
        logic [2:0]  f [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
        logic [31:0] a [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF};
        logic [31:0] b [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
        logic [31:0] e [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 16));
            wait_result(lat);
            n_cmp++; if (bus.result !== e[i]) begin n_err++; $display("FAIL div_result[%0d]: got %h want %h", i, bus.result, e[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special;
        logic [2:0]  f [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] a [6] = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB};
        logic [31:0] b [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] e [6] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 24));
            wait_result(lat);
            n_cmp++; if (bus.result !== e[i]) begin n_err++; $display("FAIL special_result[%0d]: got %h want %h", i, bus.result, e[i]); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
            n_cmp++; if (bus.out_tag !== 5'(i + 24)) begin n_err++; $display("FAIL special_tag[%0d]: got %0d want %0d", i, bus.out_tag, i + 24); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bus.out_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd9);
        wait_result(lat);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b000;
        bus.op1      = 32'd2;
        bus.op2      = 32'd2;
        bus.in_tag   = 5'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL bp_result[%0d]: got %h want 0000000e", i, bus.result); end
            n_cmp++; if (bus.out_tag !== 5'd9) begin n_err++; $display("FAIL bp_tag[%0d]: got %0d want 9", i, bus.out_tag); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release: got valid=%b busy=%b ready=%b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_ignored_req: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int n = 0;
        issue(3'b000, 32'd6, 32'd7, 5'd2);
        wait_result(lat);
        n_cmp++; if (bus.result !== 32'd42) begin n_err++; $display("FAIL b2b_first: got %h want 0000002a", bus.result); end
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b101;
        bus.op1      = 32'd100;
        bus.op2      = 32'd7;
        bus.in_tag   = 5'd3;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((!bus.busy || bus.out_valid) && n < 10);
        bus.in_valid = 1'b0;
        n_cmp++; if (lat + n !== 35) begin n_err++; $display("FAIL b2b_period: got %0d want 34", lat + n - 1); end
        wait_result(lat);
        n_cmp++; if (bus.result !== 32'd14 || bus.out_tag !== 5'd3)
            begin n_err++; $display("FAIL b2b_second: got %h tag %0d want 0000000e tag 3", bus.result, bus.out_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_reset;
        logic seen = 1'b0;
        int   lat;
        issue(3'b000, 32'd3, 32'd5, 5'd1);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL flush_idle: got busy=%b ready=%b valid=%b want 0 1 0", bus.busy, bus.in_ready, bus.out_valid); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen |= bus.out_valid;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result: got out_valid seen=%b want 0", seen); end
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_state: got busy=%b ready=%b valid=%b want 0 1 0", bus.busy, bus.in_ready, bus.out_valid); end
        n_cmp++; if (bus.result !== 32'h0 || bus.out_tag !== 5'h0)
            begin n_err++; $display("FAIL rst_mid_outputs: got %h tag %0d want 00000000 tag 0", bus.result, bus.out_tag); end
        rst = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 5'd4);
        wait_result(lat);
        n_cmp++; if (bus.result !== 32'd15 || lat !== 33)
            begin n_err++; $display("FAIL rst_fresh_mul: got %h lat %0d want 0000000f lat 33", bus.result, lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'b000;
        bus.op1       = 32'h0;
        bus.op2       = 32'h0;
        bus.in_tag    = 5'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_backpressure;
        test_back_to_back;
        test_flush_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
